// File: rtl/vending_credit_if.sv
// Coin, item and refund request inputs plus the credit, vend, deny, change and busy status outputs of vending_credit.
// The master modport drives the requests; the slave modport is the controller.
interface vending_credit_if #(
  parameter int CREDIT_W = 8
);
  logic                penny;
  logic                nickel;
  logic                dime;
  logic                quarter;
  logic                apple;
  logic                banana;
  logic                carrot;
  logic                date;
  logic                coin_return;
  logic [CREDIT_W-1:0] credit;
  logic [3:0]          vend;
  logic                deny;
  logic [3:0]          chg;
  logic                busy;
  logic                coin_rej;

  modport master (
    output penny, nickel, dime, quarter, apple, banana, carrot, date, coin_return,
    input  credit, vend, deny, chg, busy, coin_rej
  );

  modport slave (
    input  penny, nickel, dime, quarter, apple, banana, carrot, date, coin_return,
    output credit, vend, deny, chg, busy, coin_rej
  );
endinterface

// File: rtl/vending_credit.sv
// Credit accumulator and vend/change controller: one event per cycle; outputs are registered one cycle after the sampling edge.
// No backpressure: inputs are dropped while busy. COIN_REJECT_EN refuses coins that would overflow MAX_CREDIT instead of saturating.
module vending_credit #(
  parameter int CREDIT_W   = 8,
  parameter int MAX_CREDIT = 255,
  parameter int PRICE_A    = 75,
  parameter int PRICE_B    = 20,
  parameter int PRICE_C    = 30,
  parameter int PRICE_D    = 40
) (
  input logic             clk,
  input logic             reset,
  vending_credit_if.slave bus
);
  localparam int XW = CREDIT_W + 1;
  localparam logic [CREDIT_W:0] MAX_X     = XW'(MAX_CREDIT);
  localparam logic [CREDIT_W:0] V_PENNY   = XW'(1);
  localparam logic [CREDIT_W:0] V_NICKEL  = XW'(5);
  localparam logic [CREDIT_W:0] V_DIME    = XW'(10);
  localparam logic [CREDIT_W:0] V_QUARTER = XW'(25);
  localparam logic [CREDIT_W:0] P_A       = XW'(PRICE_A);
  localparam logic [CREDIT_W:0] P_B       = XW'(PRICE_B);
  localparam logic [CREDIT_W:0] P_C       = XW'(PRICE_C);
  localparam logic [CREDIT_W:0] P_D       = XW'(PRICE_D);

  typedef enum logic {IDLE, CHANGE} state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [3:0]          vend_q, vend_d;
  logic [3:0]          chg_q, chg_d;
  logic                deny_q, deny_d;
  logic [CREDIT_W:0]   cur, coin, sum, price, rem;
  logic [3:0]          item;
`ifdef COIN_REJECT_EN
  logic                rej_q, rej_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      credit_q <= '0;
      vend_q   <= '0;
      chg_q    <= '0;
      deny_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      vend_q   <= vend_d;
      chg_q    <= chg_d;
      deny_q   <= deny_d;
    end
  end

`ifdef COIN_REJECT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rej_q <= 1'b0;
    else        rej_q <= rej_d;
  end
`endif

  // One extra bit of headroom keeps the overflow compare and subtraction free of wrap-around.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    vend_d   = '0;
    chg_d    = '0;
    deny_d   = 1'b0;
`ifdef COIN_REJECT_EN
    rej_d    = 1'b0;
`endif
    cur      = {1'b0, credit_q};
    coin     = '0;
    sum      = '0;
    price    = '0;
    rem      = '0;
    item     = '0;

    if (state_q == IDLE) begin
      if (bus.coin_return) begin
        if (cur != '0) state_d = CHANGE;
      end else if (bus.penny | bus.nickel | bus.dime | bus.quarter) begin
        if (bus.penny)       coin = V_PENNY;
        else if (bus.nickel) coin = V_NICKEL;
        else if (bus.dime)   coin = V_DIME;
        else                 coin = V_QUARTER;
        sum = cur + coin;
        if (sum > MAX_X) begin
`ifdef COIN_REJECT_EN
          rej_d = 1'b1;
`else
          credit_d = MAX_X[CREDIT_W-1:0];
`endif
        end else begin
          credit_d = sum[CREDIT_W-1:0];
        end
      end else if (bus.apple | bus.banana | bus.carrot | bus.date) begin
        if (bus.apple)       begin price = P_A; item = 4'b1000; end
        else if (bus.banana) begin price = P_B; item = 4'b0100; end
        else if (bus.carrot) begin price = P_C; item = 4'b0010; end
        else                 begin price = P_D; item = 4'b0001; end
        if (cur >= price) begin
          rem      = cur - price;
          credit_d = rem[CREDIT_W-1:0];
          vend_d   = item;
        end else begin
          deny_d = 1'b1;
        end
      end
    end else begin
      // Greedy change: largest coin that still fits, one per cycle.
      if (cur >= V_QUARTER)     begin coin = V_QUARTER; chg_d = 4'b1000; end
      else if (cur >= V_DIME)   begin coin = V_DIME;    chg_d = 4'b0100; end
      else if (cur >= V_NICKEL) begin coin = V_NICKEL;  chg_d = 4'b0010; end
      else                      begin coin = V_PENNY;   chg_d = 4'b0001; end
      rem      = cur - coin;
      credit_d = rem[CREDIT_W-1:0];
      if (rem == '0) state_d = IDLE;
    end
  end

  assign bus.credit = credit_q;
  assign bus.vend   = vend_q;
  assign bus.chg    = chg_q;
  assign bus.deny   = deny_q;
  assign bus.busy   = (state_q == CHANGE);
`ifdef COIN_REJECT_EN
  assign bus.coin_rej = rej_q;
`else
  assign bus.coin_rej = 1'b0;
`endif
endmodule

// File: tb/tb_vending_credit.sv
// Directed plus random stimulus for vending_credit, compared each cycle against a queue-based credit/change model.
module tb_vending_credit;
  localparam int MAXC = 255;
  localparam int PA = 75, PB = 20, PC = 30, PD = 40;
  // Input vector order: {coin_return, penny, nickel, dime, quarter, apple, banana, carrot, date}
  localparam logic [8:0] NONE = 9'h000, RET = 9'h100, PEN = 9'h080, NIC = 9'h040, DIM = 9'h020,
                         QTR = 9'h010, APL = 9'h008, BAN = 9'h004, CAR = 9'h002, DAT = 9'h001;

  logic clk = 1'b0;
  logic reset = 1'b1;
  vending_credit_if #(.CREDIT_W(8)) vif ();

  vending_credit #(
    .CREDIT_W(8), .MAX_CREDIT(MAXC), .PRICE_A(PA), .PRICE_B(PB), .PRICE_C(PC), .PRICE_D(PD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(vif.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int   mcredit = 0;
  bit   mbusy = 0;
  int   chg_q[$];
  logic [3:0] e_vend, e_chg;
  logic e_deny, e_rej;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [8:0] in);
    {vif.coin_return, vif.penny, vif.nickel, vif.dime, vif.quarter,
     vif.apple, vif.banana, vif.carrot, vif.date} = in;
  endtask

  function automatic logic [3:0] coin_bit(input int c);
    case (c)
      25: return 4'b1000;
      10: return 4'b0100;
      5:  return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  task automatic model(input logic [8:0] in);
    int c, r, v, p;
    logic [3:0] b;
    e_vend = '0; e_chg = '0; e_deny = 1'b0; e_rej = 1'b0;
    if (mbusy) begin
      c = chg_q.pop_front();
      mcredit -= c;
      e_chg = coin_bit(c);
      if (chg_q.size() == 0) mbusy = 0;
    end else if (in[8]) begin
      if (mcredit > 0) begin
        r = mcredit;
        while (r > 0) begin
          c = (r >= 25) ? 25 : (r >= 10) ? 10 : (r >= 5) ? 5 : 1;
          chg_q.push_back(c);
          r -= c;
        end
        mbusy = 1;
      end
    end else if (|in[7:4]) begin
      v = in[7] ? 1 : in[6] ? 5 : in[5] ? 10 : 25;
      if (mcredit + v > MAXC) begin
`ifdef COIN_REJECT_EN
        e_rej = 1'b1;
`else
        mcredit = MAXC;
`endif
      end else begin
        mcredit += v;
      end
    end else if (|in[3:0]) begin
      if (in[3])      begin p = PA; b = 4'b1000; end
      else if (in[2]) begin p = PB; b = 4'b0100; end
      else if (in[1]) begin p = PC; b = 4'b0010; end
      else            begin p = PD; b = 4'b0001; end
      if (mcredit >= p) begin mcredit -= p; e_vend = b; end
      else e_deny = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".credit"}, 32'(vif.credit), 32'(mcredit));
    chk({tag, ".vend"}, 32'(vif.vend), 32'(e_vend));
    chk({tag, ".deny"}, 32'(vif.deny), 32'(e_deny));
    chk({tag, ".chg"}, 32'(vif.chg), 32'(e_chg));
    chk({tag, ".busy"}, 32'(vif.busy), 32'(mbusy));
    chk({tag, ".coin_rej"}, 32'(vif.coin_rej), 32'(e_rej));
  endtask

  task automatic step(input logic [8:0] in, input string tag);
    drive(in);
    @(posedge clk);
    #1;
    model(in);
    check_all(tag);
  endtask

  task automatic drain();
    step(RET, "drain_ret");
    for (int i = 0; i < 40 && mbusy; i++) step(NONE, "drain");
    chk("drain_done", 32'(vif.busy), 32'd0);
  endtask

  // Called #1 after an edge: pulse reset between edges and expect outputs cleared without a clock.
  task automatic async_reset(input string tag);
    drive(NONE);
    #1 reset = 1'b0;
    #1;
    chk({tag, ".credit"}, 32'(vif.credit), 32'd0);
    chk({tag, ".vend"}, 32'(vif.vend), 32'd0);
    chk({tag, ".deny"}, 32'(vif.deny), 32'd0);
    chk({tag, ".chg"}, 32'(vif.chg), 32'd0);
    chk({tag, ".busy"}, 32'(vif.busy), 32'd0);
    chk({tag, ".coin_rej"}, 32'(vif.coin_rej), 32'd0);
    mcredit = 0; mbusy = 0; chg_q.delete();
    e_vend = '0; e_chg = '0; e_deny = 1'b0; e_rej = 1'b0;
    #1 reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] rin;
    drive(NONE);
    #1 reset = 1'b0;
    #1;
    chk("rst.credit", 32'(vif.credit), 32'd0);
    chk("rst.busy", 32'(vif.busy), 32'd0);
    chk("rst.vend", 32'(vif.vend), 32'd0);
    chk("rst.chg", 32'(vif.chg), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Reset mid-stream with 40 cents of credit
    step(QTR, "r40_q"); step(DIM, "r40_d"); step(NIC, "r40_n");
    chk("r40_credit", 32'(vif.credit), 32'd40);
    async_reset("r40_rst");

    // Three quarters then an apple
    step(QTR, "qa1"); chk("qa1_credit", 32'(vif.credit), 32'd25);
    step(QTR, "qa2"); chk("qa2_credit", 32'(vif.credit), 32'd50);
    step(QTR, "qa3"); chk("qa3_credit", 32'(vif.credit), 32'd75);
    step(APL, "qa_apple");
    chk("qa_vend", 32'(vif.vend), 32'h8);
    chk("qa_zero", 32'(vif.credit), 32'd0);
    step(NONE, "qa_after");

    // Deny at 15, then dime beats banana in the same cycle
    step(DIM, "dn_d"); step(NIC, "dn_n");
    step(CAR, "dn_carrot");
    chk("dn_deny", 32'(vif.deny), 32'd1);
    chk("dn_credit", 32'(vif.credit), 32'd15);
    step(DIM | BAN, "dn_prio");
    chk("dn_prio_credit", 32'(vif.credit), 32'd25);
    chk("dn_prio_vend", 32'(vif.vend), 32'd0);
    drain();

    // Overflow at 250
    for (int i = 0; i < 10; i++) step(QTR, "ov_fill");
    chk("ov_250", 32'(vif.credit), 32'd250);
    step(QTR, "ov_q");
`ifdef COIN_REJECT_EN
    chk("ov_credit", 32'(vif.credit), 32'd250);
    chk("ov_rej", 32'(vif.coin_rej), 32'd1);
`else
    chk("ov_credit", 32'(vif.credit), 32'd255);
    chk("ov_rej", 32'(vif.coin_rej), 32'd0);
`endif
    drain();

    // Refund of 41 with a dime arriving while busy
    step(QTR, "rf_q"); step(DIM, "rf_d"); step(NIC, "rf_n"); step(PEN, "rf_p");
    step(RET, "rf_ret"); chk("rf_busy", 32'(vif.busy), 32'd1);
    step(DIM, "rf_c1"); chk("rf_c1_chg", 32'(vif.chg), 32'h8); chk("rf_c1_cr", 32'(vif.credit), 32'd16);
    step(NONE, "rf_c2"); chk("rf_c2_chg", 32'(vif.chg), 32'h4); chk("rf_c2_cr", 32'(vif.credit), 32'd6);
    step(NONE, "rf_c3"); chk("rf_c3_chg", 32'(vif.chg), 32'h2); chk("rf_c3_cr", 32'(vif.credit), 32'd1);
    step(NONE, "rf_c4"); chk("rf_c4_chg", 32'(vif.chg), 32'h1); chk("rf_c4_cr", 32'(vif.credit), 32'd0);
    chk("rf_c4_busy", 32'(vif.busy), 32'd0);
    step(NONE, "rf_idle");

    // Reset during the second change cycle of a 41-cent refund
    step(QTR, "ra_q"); step(DIM, "ra_d"); step(NIC, "ra_n"); step(PEN, "ra_p");
    step(RET, "ra_ret");
    step(NONE, "ra_c1");
    async_reset("ra_rst");
    for (int i = 0; i < 4; i++) step(NONE, "ra_quiet");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rin = '0;
      rin[8] = ($urandom_range(0, 24) == 0);
      for (int b = 0; b < 8; b++) rin[b] = ($urandom_range(0, 5) == 0);
      step(rin, "rand");
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
